// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one combinational ROM between an
// instruction-fetch port and a load port. One grant per cycle, single-cycle
// registered responses, per-port backpressure.
module rom_arbiter #(
  parameter int unsigned ROM_WORDS = 1024,
  parameter bit          BYTE_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        if_resp_ready,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  input  logic [1:0]  ld_req_size,
  input  logic        ld_req_unsigned,
  output logic        ld_req_ready,
  output logic        ld_resp_valid,
  output logic [31:0] ld_resp_data,
  output logic        ld_resp_err,
  input  logic        ld_resp_ready,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'd4;

  port_e       last_grant;
  logic        if_elig;
  logic        ld_elig;
  logic        grant_if;
  logic        grant_ld;
  logic [31:0] w;
  logic        if_err;
  logic        ld_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;

  // Eligibility and round-robin grant; a port with a stalled response is skipped
  always_comb begin
    if_elig  = if_req_valid && (!if_resp_valid || if_resp_ready);
    ld_elig  = ld_req_valid && (!ld_resp_valid || ld_resp_ready);
    grant_if = rst_n && if_elig && (!ld_elig || last_grant == PORT_LD);
    grant_ld = rst_n && ld_elig && (!if_elig || last_grant == PORT_IF);
    if_req_ready = grant_if;
    ld_req_ready = grant_ld;
  end

  // ROM address follows the granted requester, word aligned; zero when idle
  always_comb begin
    rom_addr = '0;
    if (grant_if)
      rom_addr = {if_req_addr[31:2], 2'b00};
    else if (grant_ld)
      rom_addr = {ld_req_addr[31:2], 2'b00};
  end

  // Optional byte reversal of the raw ROM word
  always_comb begin
    w = rom_data;
    if (BYTE_SWAP)
      w = {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]};
  end

  // Access-fault decode for both ports
  always_comb begin
    if_err = (if_req_addr[1:0] != 2'b00) || ({1'b0, if_req_addr} >= ROM_BYTES);
    ld_err = {1'b0, ld_req_addr} >= ROM_BYTES;
    case (ld_req_size)
      2'b01:   ld_err = ld_err || ld_req_addr[0];
      2'b10:   ld_err = ld_err || (ld_req_addr[1:0] != 2'b00);
      2'b11:   ld_err = 1'b1;
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    ld_byte = w[{ld_req_addr[1:0], 3'b000} +: 8];
    ld_half = w[{ld_req_addr[1], 4'b0000} +: 16];
    case (ld_req_size)
      2'b00:   ld_word = {{24{~ld_req_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_word = {{16{~ld_req_unsigned & ld_half[15]}}, ld_half};
      default: ld_word = w;
    endcase
  end

  // Round-robin pointer and registered responses for both ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant    <= PORT_LD;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      if_resp_err   <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
      ld_resp_err   <= 1'b0;
    end else begin
      if (grant_if)
        last_grant <= PORT_IF;
      else if (grant_ld)
        last_grant <= PORT_LD;

      if (grant_if) begin
        if_resp_valid <= 1'b1;
        if_resp_err   <= if_err;
        if_resp_data  <= if_err ? '0 : w;
      end else if (if_resp_ready) begin
        if_resp_valid <= 1'b0;
      end

      if (grant_ld) begin
        ld_resp_valid <= 1'b1;
        ld_resp_err   <= ld_err;
        ld_resp_data  <= ld_err ? '0 : ld_word;
      end else if (ld_resp_ready) begin
        ld_resp_valid <= 1'b0;
      end
    end
  end

endmodule
